// File: rtl/conv_result_collector_if.sv
// Stream bundle for conv_result_collector: scalar result beats in, packed frames out.
// The collector uses the slave modport; the PE/consumer side uses master.
interface conv_result_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 4
);
    localparam int CW = (D > 1) ? $clog2(D + 1) : 1;

    // Valid/ready: a beat moves on a cycle where valid and ready are both high.
    // The sender holds valid and data until that cycle.
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH*D-1:0] out_vector;
    logic [CW-1:0]           wr_count;
    logic                    ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_vector, wr_count, ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_vector, wr_count, ovf
    );
endinterface

// File: rtl/conv_result_collector.sv
// Gathers D result words into one packed frame (FILL/HOLD FSM, same-cycle drain/refill).
// Optional sticky overflow detection is enabled by defining CONV_COLLECT_OVF_EN.
module conv_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    conv_result_collector_if.slave  bus,
    output logic                    dbg_state
);
    localparam int CW = (D > 1) ? $clog2(D + 1) : 1;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           wr_count_q, wr_count_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH*D-1:0] vec_q, vec_d;
    logic                    in_ready;
    logic                    accept;
    logic                    drain;

    // Word k sits at the most-significant end first, so the first word of a
    // frame occupies the leading DATA_WIDTH bits, matching the conv input packing.
    always_comb begin
        in_ready    = (state_q == FILL) ? 1'b1 : bus.out_ready;
        if (flush) in_ready = 1'b0;
        accept      = bus.in_valid & in_ready;
        drain       = out_valid_q & bus.out_ready;

        state_d     = state_q;
        wr_count_d  = wr_count_q;
        out_valid_d = out_valid_q;
        vec_d       = vec_q;

        if (flush) begin
            state_d     = FILL;
            wr_count_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < D; k++) begin
                            if (int'(wr_count_q) == k)
                                vec_d[DATA_WIDTH*(D-1-k) +: DATA_WIDTH] = bus.in_data;
                        end
                        if (int'(wr_count_q) == D - 1) begin
                            state_d     = HOLD;
                            wr_count_d  = '0;
                            out_valid_d = 1'b1;
                        end else begin
                            wr_count_d  = wr_count_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        if (accept) begin
                            vec_d[DATA_WIDTH*(D-1) +: DATA_WIDTH] = bus.in_data;
                            if (D == 1) begin
                                state_d     = HOLD;
                                wr_count_d  = '0;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d     = FILL;
                                wr_count_d  = CW'(1);
                                out_valid_d = 1'b0;
                            end
                        end else begin
                            state_d     = FILL;
                            wr_count_d  = '0;
                            out_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d     = FILL;
                    wr_count_d  = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FILL;
            wr_count_q  <= '0;
            out_valid_q <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            out_valid_q <= out_valid_d;
            vec_q       <= vec_d;
        end
    end

`ifdef CONV_COLLECT_OVF_EN
    logic ovf_q, ovf_d;

    // A beat offered while not ready would be lost by a producer that ignores ready.
    always_comb begin
        ovf_d = ovf_q | (bus.in_valid & ~in_ready);
        if (flush) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vector = vec_q;
    assign bus.wr_count   = wr_count_q;
    assign dbg_state      = (state_q == HOLD);
endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector (DATA_WIDTH=16, D=4): vector table plus
// hand-written reset, reset-mid-frame and latency sequences.
module tb_conv_result_collector;
    localparam int DW = 16;
    localparam int ND = 4;

    logic clk;
    logic reset;
    logic flush;
    logic dbg_state;

    int checks   = 0;
    int failures = 0;

    conv_result_collector_if #(.DATA_WIDTH(DW), .D(ND)) bus ();

    conv_result_collector #(.DATA_WIDTH(DW), .D(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [2:0]  exp_wr;
        logic        chk_vec;
        logic [63:0] exp_vec;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fl, logic iv, logic [15:0] d, logic ordy,
                                logic ir, logic ov, logic [2:0] wr, logic cv,
                                logic [63:0] ev, logic eo);
        vec_t v;
        v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_wr = wr;
        v.chk_vec = cv; v.exp_vec = ev; v.exp_ovf = eo;
        return v;
    endfunction

    function automatic logic ovf_exp(logic v);
`ifdef CONV_COLLECT_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic push_word(input logic [15:0] d, input logic ordy);
        @(negedge clk);
        drive(1'b0, 1'b1, d, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;

        // Frame 1 with out_ready=1, drain, back to FILL.
        tbl.push_back(mk(0,1,16'h1111,1, 1,0,3'd1,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h2222,1, 1,0,3'd2,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h3333,1, 1,0,3'd3,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h4444,1, 1,1,3'd0,1,64'h1111_2222_3333_4444,0));
        tbl.push_back(mk(0,0,16'h0000,1, 1,0,3'd0,1,64'h1111_2222_3333_4444,0));
        // Frame held under backpressure, then drain with same-cycle refill.
        tbl.push_back(mk(0,1,16'h6661,0, 1,0,3'd1,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h6662,0, 1,0,3'd2,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h6663,0, 1,0,3'd3,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h6664,0, 1,1,3'd0,1,64'h6661_6662_6663_6664,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,16'hdead,0, 0,1,3'd0,1,64'h6661_6662_6663_6664,1));
        tbl.push_back(mk(0,1,16'h5555,1, 1,0,3'd1,1,64'h5555_6662_6663_6664,1));
        tbl.push_back(mk(0,1,16'h7772,1, 1,0,3'd2,0,64'h0,1));
        tbl.push_back(mk(0,1,16'h7773,1, 1,0,3'd3,0,64'h0,1));
        tbl.push_back(mk(0,1,16'h7774,1, 1,1,3'd0,1,64'h5555_7772_7773_7774,1));
        tbl.push_back(mk(0,0,16'h0000,1, 1,0,3'd0,0,64'h0,1));
        // Partial frame aborted by flush; vector not cleared, ovf cleared.
        tbl.push_back(mk(0,1,16'haaaa,0, 1,0,3'd1,0,64'h0,1));
        tbl.push_back(mk(0,1,16'hbbbb,0, 1,0,3'd2,1,64'haaaa_bbbb_7773_7774,1));
        tbl.push_back(mk(1,1,16'hcccc,1, 0,0,3'd0,1,64'haaaa_bbbb_7773_7774,0));
        tbl.push_back(mk(0,1,16'h0001,0, 1,0,3'd1,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h0002,0, 1,0,3'd2,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h0003,0, 1,0,3'd3,0,64'h0,0));
        tbl.push_back(mk(0,1,16'h0004,0, 1,1,3'd0,1,64'h0001_0002_0003_0004,0));
        // Offer while held (ovf sets), then flush discards the held frame.
        tbl.push_back(mk(0,1,16'h9999,0, 0,1,3'd0,1,64'h0001_0002_0003_0004,1));
        tbl.push_back(mk(1,0,16'h0000,0, 0,0,3'd0,1,64'h0001_0002_0003_0004,0));

        // Reset held two cycles with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 16'hffff)), 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'h0);
        check("reset wr_count", 64'(bus.wr_count), 64'h0);
        check("reset in_ready", 64'(bus.in_ready), 64'h1);
        check("reset out_vector", bus.out_vector, 64'h0);
        check("reset ovf", 64'(bus.ovf), 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #1;
            check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
            check($sformatf("v%0d state", i), 64'(dbg_state), 64'(tbl[i].exp_ov));
            check($sformatf("v%0d wr_count", i), 64'(bus.wr_count), 64'(tbl[i].exp_wr));
            check($sformatf("v%0d ovf", i), 64'(bus.ovf), 64'(ovf_exp(tbl[i].exp_ovf)));
            if (tbl[i].chk_vec)
                check($sformatf("v%0d out_vector", i), bus.out_vector, tbl[i].exp_vec);
        end

        // Reset in the middle of a frame.
        push_word(16'h0101, 1'b0);
        push_word(16'h0202, 1'b0);
        push_word(16'h0303, 1'b0);
        check("mid wr_count", 64'(bus.wr_count), 64'h3);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 16'hffff, 1'b0);
        @(posedge clk);
        #1;
        check("mid reset out_valid", 64'(bus.out_valid), 64'h0);
        check("mid reset wr_count", 64'(bus.wr_count), 64'h0);
        check("mid reset out_vector", bus.out_vector, 64'h0);
        check("mid reset ovf", 64'(bus.ovf), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check("mid reset in_ready", 64'(bus.in_ready), 64'h1);

        // Fresh frame; out_valid must be visible right after the edge taking word 4.
        push_word(16'h0b01, 1'b0);
        push_word(16'h0b02, 1'b0);
        push_word(16'h0b03, 1'b0);
        push_word(16'h0b04, 1'b0);
        lat = 0;
        while (!bus.out_valid && lat < 4) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("fresh frame latency", 64'(lat), 64'h0);
        check("fresh frame out_valid", 64'(bus.out_valid), 64'h1);
        check("fresh frame out_vector", bus.out_vector, 64'h0b01_0b02_0b03_0b04);
        check("fresh frame ovf", 64'(bus.ovf), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
